// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port BRAM responder: state encoding,
// default geometry and the read-data source select.
package bram_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Where q_X comes from in the cycle after an access.
  typedef enum logic [1:0] {
    Q_ZERO,
    Q_MEM,
    Q_BYP
  } q_src_t;

endpackage

// File: rtl/dp_ram_core.sv
// Bare dual-port array: two synchronous write ports (A wins on the same
// address) and two synchronous read ports that return the pre-write word.
module dp_ram_core
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Port A is written last so it overrides port B on a shared address.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wdata_b;
    if (we_a) mem[addr_a] <= wdata_a;
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/dp_bram_responder.sv
// Dual-port BRAM responder: self-clears after reset two words per cycle,
// then serves write-first/read-old traffic and flags same-address writes.
module dp_bram_responder
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_a,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  ready,
  output logic                  collision
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP = ADDR_WIDTH'(2);
  // Last even address; collapses to 0 for a two-word array.
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ~PTR_ONE;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  clearing;

  logic                  c_we_a, c_we_b;
  logic [ADDR_WIDTH-1:0] c_addr_a, c_addr_b;
  logic [DATA_WIDTH-1:0] c_data_a, c_data_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  q_src_t                src_a, src_b;
  logic [DATA_WIDTH-1:0] byp_a, byp_b;

  assign clearing = (state == ST_CLEAR);
  assign ready    = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (clearing) begin
      clr_ptr <= clr_ptr + PTR_STEP;
      if (clr_ptr == PTR_LAST) state <= ST_RUN;
    end
  end

  // During CLEAR the array ports belong to the clear walker.
  always_comb begin
    c_we_a   = we_a;
    c_we_b   = we_b;
    c_addr_a = addr_a;
    c_addr_b = addr_b;
    c_data_a = data_a;
    c_data_b = data_b;
    if (clearing) begin
      c_we_a   = 1'b1;
      c_we_b   = 1'b1;
      c_addr_a = clr_ptr;
      c_addr_b = clr_ptr | PTR_ONE;
      c_data_a = INIT_VALUE;
      c_data_b = INIT_VALUE;
    end
  end

  dp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .we_a    (c_we_a),
    .addr_a  (c_addr_a),
    .wdata_a (c_data_a),
    .we_b    (c_we_b),
    .addr_b  (c_addr_b),
    .wdata_b (c_data_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Own-port writes bypass the array so q_X shows the written word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_a     <= Q_ZERO;
      src_b     <= Q_ZERO;
      byp_a     <= '0;
      byp_b     <= '0;
      collision <= 1'b0;
    end else if (clearing) begin
      src_a     <= Q_ZERO;
      src_b     <= Q_ZERO;
      collision <= 1'b0;
    end else begin
      src_a     <= we_a ? Q_BYP : Q_MEM;
      src_b     <= we_b ? Q_BYP : Q_MEM;
      if (we_a) byp_a <= data_a;
      if (we_b) byp_b <= data_b;
      collision <= we_a && we_b && (addr_a == addr_b);
    end
  end

  always_comb begin
    q_a = '0;
    q_b = '0;
    case (src_a)
      Q_MEM:   q_a = rdata_a;
      Q_BYP:   q_a = byp_a;
      default: q_a = '0;
    endcase
    case (src_b)
      Q_MEM:   q_b = rdata_b;
      Q_BYP:   q_b = byp_b;
      default: q_b = '0;
    endcase
  end

endmodule

// File: tb/tb_dp_bram_responder.sv
// Scoreboard bench for dp_bram_responder: each op pushes its expected
// response; a monitor pops and compares one cycle later.
module tb_dp_bram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [15:0] q_a, q_b;
  logic        ready, collision;

  typedef struct {
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ec;
    string       name;
  } exp_t;

  exp_t sb[$];
  bit   issued = 1'b0;
  bit   pend = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  dp_bram_responder #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (10),
    .INIT_VALUE (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_a    (data_a),
    .data_b    (data_b),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .ready     (ready),
    .collision (collision)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pend <= issued;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Called right after a falling edge; returns at the next falling edge.
  task automatic op(input bit wa, input logic [9:0] aa, input logic [15:0] da,
                    input bit wb, input logic [9:0] ab, input logic [15:0] db,
                    input logic [15:0] ea, input logic [15:0] eb, input bit ec,
                    input string nm);
    exp_t e;
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    e.ea = ea; e.eb = eb; e.ec = ec; e.name = nm;
    sb.push_back(e);
    issued = 1'b1;
    @(negedge clk);
    issued = 1'b0;
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  // Counts rising edges from reset release until ready; optionally pokes a
  // client write at edge 10 that must be ignored.
  task automatic wait_ready(input bit inject, input string nm);
    int n;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (ready) break;
      if (n == 5) begin
        chk({nm, "_clear_q_a"}, 32'(q_a), 0);
        chk({nm, "_clear_coll"}, 32'(collision), 0);
      end
      if (inject && n == 9) begin
        we_a = 1'b1; addr_a = 10'd0; data_a = 16'd9;
      end else begin
        we_a = 1'b0;
      end
    end
    we_a = 1'b0;
    chk({nm, "_clear_edges"}, 32'(n), 512);
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (pend) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_q_a"}, 32'(q_a), 32'(e.ea));
            chk({e.name, "_q_b"}, 32'(q_b), 32'(e.eb));
            chk({e.name, "_coll"}, 32'(collision), 32'(e.ec));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_q_a", 32'(q_a), 0);
    chk("rst_q_b", 32'(q_b), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_coll", 32'(collision), 0);
    reset = 1'b1;
    wait_ready(1'b1, "init");

    op(0, 10'd0,   16'd0,  0, 10'd1023, 16'd0,  16'd0,  16'd0,  0, "rd_0_1023");
    op(0, 10'd0,   16'd0,  0, 10'd0,    16'd0,  16'd0,  16'd0,  0, "rd_ignored_wr");
    op(1, 10'd0,   16'd8,  1, 10'd1,    16'd10, 16'd8,  16'd10, 0, "wr_8_10");
    op(0, 10'd0,   16'd0,  0, 10'd1,    16'd0,  16'd8,  16'd10, 0, "rd_8_10");
    op(1, 10'd0,   16'd9,  1, 10'd1,    16'd11, 16'd9,  16'd11, 0, "wr_9_11");
    op(0, 10'd0,   16'd0,  0, 10'd1,    16'd0,  16'd9,  16'd11, 0, "rd_9_11");
    op(1, 10'd5,   16'd3,  1, 10'd5,    16'd15, 16'd3,  16'd15, 1, "wr_coll");
    op(0, 10'd5,   16'd0,  0, 10'd5,    16'd0,  16'd3,  16'd3,  0, "rd_coll");
    op(1, 10'd510, 16'd3,  0, 10'd510,  16'd0,  16'd3,  16'd0,  0, "wa_rb_old");
    op(0, 10'd510, 16'd0,  0, 10'd510,  16'd0,  16'd3,  16'd3,  0, "rd_510");
    op(0, 10'd1,   16'd0,  1, 10'd1,    16'd77, 16'd11, 16'd77, 0, "wb_ra_old");
    op(1, 10'd7,   16'd21, 1, 10'd8,    16'd22, 16'd21, 16'd22, 0, "wr_diff");
    op(0, 10'd8,   16'd0,  0, 10'd7,    16'd0,  16'd22, 16'd21, 0, "rd_swap");
    op(1, 10'd511, 16'd9,  0, 10'd1,    16'd0,  16'd9,  16'd77, 0, "wr_511");

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_q_a", 32'(q_a), 0);
    chk("midrst_q_b", 32'(q_b), 0);
    chk("midrst_ready", 32'(ready), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready(1'b0, "reclr");
    op(0, 10'd511, 16'd0,  0, 10'd5,    16'd0,  16'd0,  16'd0,  0, "rd_after_reclr");

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
